block_memory: RTL

//  Block-granular main data memory sitting directly below data_cache.

---
 rtl/block_memory.sv | 89 ++++++++
 1 files changed

// File: rtl/block_memory.sv
// Block-granular backing store below the data cache: 32-bit block reads and writes
// over a read/write/busywait handshake with a fixed multi-cycle access latency.
module block_memory #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   counter_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  data_reg;
    logic               op_write_reg;
    logic [DATA_W-1:0]  readdata_reg;
    logic               busywait_reg;

    // Reset must clear every block, so storage is a flop array rather than a RAM macro.
    logic [DATA_W-1:0]  mem_reg [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            op_write_reg <= 1'b0;
            readdata_reg <= '0;
            busywait_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (read || write) begin
                        addr_reg     <= address;
                        data_reg     <= writedata;
                        op_write_reg <= write;   // write wins when both are requested
                        counter_reg  <= CNT_W'(LATENCY - 1);
                        busywait_reg <= 1'b1;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter_reg != '0) begin
                        counter_reg <= counter_reg - CNT_W'(1);
                    end else begin
                        if (op_write_reg) begin
                            mem_reg[addr_reg] <= data_reg;
                        end else begin
                            readdata_reg <= mem_reg[addr_reg];
                        end
                        busywait_reg <= 1'b0;
                        state_reg    <= RELEASE;
                    end
                end
                RELEASE: begin
                    // One dead cycle so a request line left high cannot retrigger at once.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign readdata = readdata_reg;
    assign busywait = busywait_reg;

endmodule
